// File: rtl/pj_data_mem_if.sv
// Data-memory port bundle between the core back end (master) and pj_data_mem (slave).
// Reads are combinational: r_data answers r_v/r_addr in the same cycle.
interface pj_data_mem_if #(
    parameter int word_size_p = 16
);
    logic                   w_v;
    logic [word_size_p-1:0] w_addr;
    logic [word_size_p-1:0] w_data;
    logic                   r_v;
    logic [word_size_p-1:0] r_addr;
    logic [word_size_p-1:0] r_data;

    modport master (
        output w_v, w_addr, w_data, r_v, r_addr,
        input  r_data
    );

    modport slave (
        input  w_v, w_addr, w_data, r_v, r_addr,
        output r_data
    );
endinterface

// File: rtl/pj_data_mem.sv
// Word-addressed RAM plus a four-register MMIO page (console FIFO, cycle counter,
// halt, console drop counter) answering the core's data-memory port.
module pj_data_mem #(
    parameter int word_size_p = 16,
    parameter int ram_els_p   = 4096,
    parameter int mmio_base_p = 'hFF00,
    parameter int cons_els_p  = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    pj_data_mem_if.slave           mem,
    output logic                   cons_v_o,
    output logic [7:0]             cons_data_o,
    input  logic                   cons_yumi_i,
    output logic                   halt_o,
    output logic [word_size_p-1:0] halt_code_o,
    output logic                   bad_addr_o
);
    localparam int RAM_AW  = $clog2(ram_els_p);
    localparam int CONS_AW = $clog2(cons_els_p);
    localparam int CNT_W   = CONS_AW + 1;

    localparam logic [word_size_p-1:0] RAM_LIM = word_size_p'(ram_els_p);
    localparam logic [word_size_p-1:0] BASE    = word_size_p'(mmio_base_p);
    localparam logic [word_size_p-1:0] PAGE    = word_size_p'(4);
    localparam logic [CNT_W-1:0]       CNT_MAX = CNT_W'(cons_els_p);

    logic [word_size_p-1:0] r_ram  [ram_els_p];
    logic [7:0]             r_cons [cons_els_p];

    logic [CONS_AW-1:0]     r_head;
    logic [CONS_AW-1:0]     r_tail;
    logic [CNT_W-1:0]       r_count;
    logic [word_size_p-1:0] r_cycles;
    logic [word_size_p-1:0] r_drops;
    logic [word_size_p-1:0] r_halt_code;
    logic                   r_halt;
    logic                   r_bad;

    logic [word_size_p-1:0] w_w_off;
    logic [word_size_p-1:0] w_r_off;
    logic                   w_w_ram;
    logic                   w_w_mmio;
    logic                   w_r_ram;
    logic                   w_r_mmio;
    logic                   w_we;
    logic                   w_we_ram;
    logic                   w_we_cons;
    logic                   w_we_cyc;
    logic                   w_we_halt;
    logic                   w_we_drops;
    logic                   w_w_bad;
    logic                   w_r_bad;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_deq;
    logic                   w_drop;
    logic                   w_enq;
    logic [word_size_p-1:0] w_rdata;

    // Address decode for both ports
    assign w_w_off  = mem.w_addr - BASE;
    assign w_r_off  = mem.r_addr - BASE;
    assign w_w_ram  = mem.w_addr < RAM_LIM;
    assign w_r_ram  = mem.r_addr < RAM_LIM;
    assign w_w_mmio = (mem.w_addr >= BASE) && (w_w_off < PAGE);
    assign w_r_mmio = (mem.r_addr >= BASE) && (w_r_off < PAGE);

    assign w_we       = mem.w_v && !reset_i;
    assign w_we_ram   = w_we && w_w_ram;
    assign w_we_cons  = w_we && w_w_mmio && (w_w_off[1:0] == 2'd0);
    assign w_we_cyc   = w_we && w_w_mmio && (w_w_off[1:0] == 2'd1);
    assign w_we_halt  = w_we && w_w_mmio && (w_w_off[1:0] == 2'd2);
    assign w_we_drops = w_we && w_w_mmio && (w_w_off[1:0] == 2'd3);
    assign w_w_bad    = mem.w_v && !w_w_ram && !w_w_mmio;
    assign w_r_bad    = mem.r_v && !w_r_ram && !w_r_mmio;

    // A full FIFO still accepts a byte when the head leaves in the same cycle
    assign w_full  = r_count == CNT_MAX;
    assign w_empty = r_count == '0;
    assign w_deq   = cons_yumi_i && !w_empty;
    assign w_drop  = w_we_cons && w_full && !cons_yumi_i;
    assign w_enq   = w_we_cons && !w_drop;

    always_ff @(posedge clk_i) begin
        if (w_we_ram) begin
            r_ram[mem.w_addr[RAM_AW-1:0]] <= mem.w_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_cons[r_tail] <= mem.w_data[7:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_cycles    <= '0;
            r_drops     <= '0;
            r_halt      <= 1'b0;
            r_halt_code <= '0;
            r_bad       <= 1'b0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + CONS_AW'(1);
            end
            if (w_deq) begin
                r_head <= r_head + CONS_AW'(1);
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_enq && w_deq) begin
                r_count <= r_count - CNT_W'(1);
            end

            if (w_we_drops) begin
                r_drops <= '0;
            end else if (w_drop && (r_drops != '1)) begin
                r_drops <= r_drops + word_size_p'(1);
            end

            if (w_we_cyc) begin
                r_cycles <= '0;
            end else if (!r_halt) begin
                r_cycles <= r_cycles + word_size_p'(1);
            end

            if (w_we_halt && !r_halt) begin
                r_halt      <= 1'b1;
                r_halt_code <= mem.w_data;
            end

            if (w_w_bad || w_r_bad) begin
                r_bad <= 1'b1;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (mem.r_v && w_r_ram) begin
            w_rdata = r_ram[mem.r_addr[RAM_AW-1:0]];
        end else if (mem.r_v && w_r_mmio) begin
            case (w_r_off[1:0])
                2'd0:    w_rdata = word_size_p'({r_count, w_full, w_empty});
                2'd1:    w_rdata = r_cycles;
                2'd2:    w_rdata = word_size_p'(r_halt);
                default: w_rdata = r_drops;
            endcase
        end
    end

    assign mem.r_data  = w_rdata;
    assign cons_v_o    = !w_empty;
    assign cons_data_o = r_cons[r_head];
    assign halt_o      = r_halt;
    assign halt_code_o = r_halt_code;
    assign bad_addr_o  = r_bad;
endmodule

// File: tb/tb_pj_data_mem.sv
// Bench for pj_data_mem: directed scenarios with literal expectations, then
// random traffic checked every cycle against a queue/array reference model.
module tb_pj_data_mem;
    localparam int W    = 16;
    localparam int RAM  = 4096;
    localparam int BASE = 'hFF00;
    localparam int CE   = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         cons_v;
    logic [7:0]   cons_data;
    logic         yumi;
    logic         halt;
    logic [W-1:0] hcode;
    logic         bad;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pj_data_mem_if #(.word_size_p(W)) bus ();

    pj_data_mem #(
        .word_size_p(W),
        .ram_els_p  (RAM),
        .mmio_base_p(BASE),
        .cons_els_p (CE)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .mem        (bus),
        .cons_v_o   (cons_v),
        .cons_data_o(cons_data),
        .cons_yumi_i(yumi),
        .halt_o     (halt),
        .halt_code_o(hcode),
        .bad_addr_o (bad)
    );

    // Reference model state
    logic [W-1:0] m_ram [RAM];
    bit           m_known [RAM];
    byte unsigned q [$];
    logic [W-1:0] m_cyc;
    logic [W-1:0] m_drops;
    logic [W-1:0] m_code;
    bit           m_halt;
    bit           m_bad;
    bit           m_ok = 1'b0;

    function automatic bit is_mmio(input int a);
        return (a >= BASE) && (a <= BASE + 3);
    endfunction

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        int  wa;
        int  ra;
        bit  full;
        bit  old_halt;
        bit  cyc_clr;
        wa = int'(bus.w_addr);
        ra = int'(bus.r_addr);
        if (reset) begin
            q.delete();
            m_cyc   = '0;
            m_drops = '0;
            m_code  = '0;
            m_halt  = 1'b0;
            m_bad   = 1'b0;
            m_ok    = 1'b1;
        end else if (m_ok) begin
            full     = q.size() == CE;
            old_halt = m_halt;
            cyc_clr  = 1'b0;
            if (yumi && q.size() > 0) void'(q.pop_front());
            if (bus.w_v) begin
                if (wa < RAM) begin
                    m_ram[wa]   = bus.w_data;
                    m_known[wa] = 1'b1;
                end else if (is_mmio(wa)) begin
                    case (wa - BASE)
                        0: begin
                            if (full && !yumi) begin
                                if (m_drops != 16'hFFFF) m_drops = m_drops + 1'b1;
                            end else begin
                                q.push_back(bus.w_data[7:0]);
                            end
                        end
                        1: cyc_clr = 1'b1;
                        2: if (!m_halt) begin
                            m_halt = 1'b1;
                            m_code = bus.w_data;
                        end
                        default: m_drops = '0;
                    endcase
                end else begin
                    m_bad = 1'b1;
                end
            end
            if (bus.r_v && !(ra < RAM) && !is_mmio(ra)) m_bad = 1'b1;
            if (cyc_clr) m_cyc = '0;
            else if (!old_halt) m_cyc = m_cyc + 1'b1;
        end
    end

    // Compare process: every cycle once the model has seen a reset edge
    always @(negedge clk) begin : compare
        int           ra;
        logic [W-1:0] exp;
        bit           known;
        if (m_ok) begin
            ra    = int'(bus.r_addr);
            exp   = '0;
            known = 1'b1;
            if (bus.r_v) begin
                if (ra < RAM) begin
                    known = m_known[ra];
                    exp   = m_ram[ra];
                end else if (is_mmio(ra)) begin
                    case (ra - BASE)
                        0: exp = W'(q.size() * 4 + (q.size() == CE ? 2 : 0)
                                    + (q.size() == 0 ? 1 : 0));
                        1: exp = m_cyc;
                        2: exp = W'(m_halt);
                        default: exp = m_drops;
                    endcase
                end
            end
            if (known) check("r_data", bus.r_data, exp);
            check("cons_v", W'(cons_v), W'(q.size() != 0));
            if (q.size() != 0) check("cons_data", W'(cons_data), W'(q[0]));
            if (yumi) check("yumi_legal", W'(cons_v), W'(1));
            check("halt", W'(halt), W'(m_halt));
            check("halt_code", hcode, m_code);
            check("bad_addr", W'(bad), W'(m_bad));
        end
    end

    // ymode: 0 no pop, 1 pop, 2 random pop when the model holds bytes
    task automatic step(input bit rst, input bit wv, input int wa, input int wd,
                        input bit rv, input int ra, input int ymode);
        @(posedge clk);
        #1;
        reset      = rst;
        bus.w_v    = wv;
        bus.w_addr = W'(wa);
        bus.w_data = W'(wd);
        bus.r_v    = rv;
        bus.r_addr = W'(ra);
        yumi = (ymode == 1) ||
               (ymode == 2 && q.size() > 0 && $urandom_range(1) == 1);
        @(negedge clk);
        #1;
    endtask

    task automatic rd(input int ra);
        step(0, 0, 0, 0, 1, ra, 0);
    endtask

    task automatic wr(input int wa, input int wd);
        step(0, 1, wa, wd, 0, 0, 0);
    endtask

    function automatic int pick_addr();
        int r;
        int o;
        r = $urandom_range(19);
        if (r < 10) return $urandom_range(31);
        if (r < 12) return $urandom_range(RAM - 1);
        if (r < 19) begin
            o = $urandom_range(9);
            if (o < 6) return BASE;
            if (o < 8) return BASE + 1;
            if (o < 9) return BASE + 3;
            return BASE + 2;
        end
        return ($urandom_range(1) == 1) ? $urandom_range(BASE + 4, 16'hFFFF)
                                        : $urandom_range(16'h1000, 16'hFEFF);
    endfunction

    initial begin
        reset      = 1'b1;
        bus.w_v    = 1'b0;
        bus.w_addr = '0;
        bus.w_data = '0;
        bus.r_v    = 1'b0;
        bus.r_addr = '0;
        yumi       = 1'b0;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);

        // Cycle counter after reset release, then clear
        rd(BASE + 1);
        check("cyc_0", bus.r_data, 16'd0);
        rd(BASE + 1);
        check("cyc_1", bus.r_data, 16'd1);
        for (int i = 2; i <= 5; i++) rd(BASE + 1);
        check("cyc_5", bus.r_data, 16'd5);
        step(0, 1, BASE + 1, 0, 1, BASE + 1, 0);
        check("cyc_pre_clr", bus.r_data, 16'd6);
        rd(BASE + 1);
        check("cyc_clr", bus.r_data, 16'd0);
        rd(BASE + 1);
        check("cyc_after_clr", bus.r_data, 16'd1);

        // RAM write then read; same-cycle read sees the old word
        wr('h10, 'hBEEF);
        rd('h10);
        check("ram_beef", bus.r_data, 16'hBEEF);
        step(0, 1, 'h10, 'h1234, 1, 'h10, 0);
        check("ram_no_fwd", bus.r_data, 16'hBEEF);
        rd('h10);
        check("ram_1234", bus.r_data, 16'h1234);

        // Console enqueue and pop
        wr(BASE, 'h41);
        wr(BASE, 'h42);
        wr(BASE, 'h43);
        rd(BASE);
        check("cons_3", bus.r_data, 16'h000C);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0, 1);
            check("cons_pop", W'(cons_data), W'(8'h41 + i));
        end
        rd(BASE);
        check("cons_empty", bus.r_data, 16'h0001);
        check("cons_v_low", W'(cons_v), 16'd0);

        // Overflow: 10 bytes into 8 slots
        for (int i = 0; i < 10; i++) wr(BASE, 'h60 + i);
        rd(BASE);
        check("cons_full", bus.r_data, 16'h0022);
        rd(BASE + 3);
        check("drops_2", bus.r_data, 16'd2);
        step(0, 1, BASE, 'h7A, 0, 0, 1);
        rd(BASE);
        check("full_yumi_cnt", bus.r_data, 16'h0022);
        rd(BASE + 3);
        check("full_yumi_drops", bus.r_data, 16'd2);

        // Reset while the FIFO is full
        step(1, 1, BASE, 'h55, 0, 0, 0);
        rd(BASE);
        check("rst_cons", bus.r_data, 16'h0001);
        check("rst_cons_v", W'(cons_v), 16'd0);
        rd(BASE + 3);
        check("rst_drops", bus.r_data, 16'd0);
        rd('h10);
        check("rst_ram_kept", bus.r_data, 16'h1234);

        // Halt: first write wins, counter freezes
        step(1, 0, 0, 0, 0, 0, 0);
        wr(BASE + 2, 'h0007);
        wr(BASE + 2, 'h0009);
        check("halt_set", W'(halt), 16'd1);
        check("halt_code", hcode, 16'h0007);
        rd(BASE + 1);
        check("halt_cyc_a", bus.r_data, 16'd1);
        rd(BASE + 1);
        check("halt_cyc_b", bus.r_data, 16'd1);
        rd(BASE + 2);
        check("halt_rd", bus.r_data, 16'd1);
        check("halt_code_kept", hcode, 16'h0007);

        // Unmapped read
        rd('h8000);
        check("bad_rd_data", bus.r_data, 16'd0);
        check("bad_pre", W'(bad), 16'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("bad_set", W'(bad), 16'd1);
        step(0, 0, 0, 0, 0, 0, 0);
        check("bad_sticky", W'(bad), 16'd1);

        // Random traffic
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(99) == 0,
                 $urandom_range(1) == 1, pick_addr(), int'($urandom_range(16'hFFFF)),
                 $urandom_range(9) < 7, pick_addr(), 2);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
